// File: rtl/cpu6_memstage.sv
// cpu6 MEM stage: load/store sequencing on a req/ack data bus with lane steering
// and load extension; non-memory results pass straight through to MEM/WB.
module cpu6_memstage #(
    parameter int XLEN        = 64,
    parameter int RFIDX_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   memreadE2M,
    input  logic                   memwriteE2M,
    input  logic [2:0]             funct3E2M,
    input  logic [XLEN-1:0]        aluresE2M,
    input  logic [XLEN-1:0]        wdataE2M,
    input  logic                   regwriteE2M,
    input  logic [RFIDX_WIDTH-1:0] writeregE2M,
    input  logic                   flushM,
    output logic                   regwriteM,
    output logic [RFIDX_WIDTH-1:0] writeregM,
    output logic [XLEN-1:0]        rdM,
    output logic                   stallM,
    output logic                   excM,
    output logic                   dbus_req,
    output logic                   dbus_we,
    output logic [XLEN-1:0]        dbus_addr,
    output logic [XLEN-1:0]        dbus_wdata,
    output logic [XLEN/8-1:0]      dbus_wstrb,
    input  logic                   dbus_ack,
    input  logic [XLEN-1:0]        dbus_rdata,
    input  logic                   dbus_err
);

    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]             state, state_nx;
    logic [XLEN-1:0]        addr_q, wdata_q, rdata_q;
    logic [2:0]             funct3_q;
    logic                   we_q, regwrite_q, err_q;
    logic [RFIDX_WIDTH-1:0] writereg_q;

    logic                   memop, misaligned, illegal, start;
    logic [OFF_W-1:0]       off_q;
    logic [XLEN-1:0]        shifted, load_fmt, wdata_rep;
    logic [STRB_W-1:0]      size_mask;

    assign memop = (memreadE2M | memwriteE2M) & ~flushM;
    assign off_q = addr_q[OFF_W-1:0];

    always_comb begin
        misaligned = 1'b0;
        case (funct3E2M[1:0])
            2'b01:   misaligned = aluresE2M[0];
            2'b10:   misaligned = |aluresE2M[1:0];
            2'b11:   misaligned = |aluresE2M[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign illegal = (funct3E2M == 3'b111) | (memwriteE2M & funct3E2M[2]);
    assign start   = (state == IDLE) & memop & ~misaligned & ~illegal;

    // Load data is shifted down to its byte offset before size/sign handling.
    assign shifted = dbus_rdata >> {off_q, 3'b000};

    always_comb begin
        load_fmt = shifted;
        case (funct3_q)
            3'b000:  load_fmt = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            3'b001:  load_fmt = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b010:  load_fmt = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            3'b100:  load_fmt = {{(XLEN-8){1'b0}},  shifted[7:0]};
            3'b101:  load_fmt = {{(XLEN-16){1'b0}}, shifted[15:0]};
            3'b110:  load_fmt = {{(XLEN-32){1'b0}}, shifted[31:0]};
            default: load_fmt = shifted;
        endcase
        if (we_q) load_fmt = '0;
    end

    always_comb begin
        wdata_rep = wdata_q;
        size_mask = '1;
        case (funct3_q[1:0])
            2'b00: begin
                wdata_rep = {STRB_W{wdata_q[7:0]}};
                size_mask = STRB_W'(1);
            end
            2'b01: begin
                wdata_rep = {(STRB_W/2){wdata_q[15:0]}};
                size_mask = STRB_W'(3);
            end
            2'b10: begin
                wdata_rep = {(STRB_W/4){wdata_q[31:0]}};
                size_mask = STRB_W'(15);
            end
            default: begin
                wdata_rep = wdata_q;
                size_mask = '1;
            end
        endcase
    end

    // A flush while the bus is busy cannot abort the access, so DRAIN waits out the ack.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? BUSY : IDLE;
            BUSY: begin
                if (dbus_ack)    state_nx = flushM ? IDLE : DONE;
                else if (flushM) state_nx = DRAIN;
            end
            DONE:    state_nx = IDLE;
            DRAIN:   state_nx = dbus_ack ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            funct3_q   <= '0;
            we_q       <= 1'b0;
            regwrite_q <= 1'b0;
            err_q      <= 1'b0;
            writereg_q <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                addr_q     <= aluresE2M;
                wdata_q    <= wdataE2M;
                funct3_q   <= funct3E2M;
                we_q       <= memwriteE2M;
                regwrite_q <= regwriteE2M;
                writereg_q <= writeregE2M;
            end
            if (state == BUSY && dbus_ack) begin
                rdata_q <= load_fmt;
                err_q   <= dbus_err;
            end
        end
    end

    // Outputs are forced low while reset is held, including the combinational paths.
    always_comb begin
        regwriteM  = 1'b0;
        writeregM  = '0;
        rdM        = '0;
        stallM     = 1'b0;
        excM       = 1'b0;
        dbus_req   = 1'b0;
        dbus_we    = 1'b0;
        dbus_addr  = '0;
        dbus_wdata = '0;
        dbus_wstrb = '0;
        if (reset) begin
            case (state)
                IDLE: begin
                    writeregM = writeregE2M;
                    rdM       = aluresE2M;
                    if (memop) begin
                        excM   = misaligned | illegal;
                        stallM = ~(misaligned | illegal);
                    end else begin
                        regwriteM = regwriteE2M & ~flushM;
                    end
                end
                BUSY, DRAIN: begin
                    stallM     = 1'b1;
                    writeregM  = writereg_q;
                    dbus_req   = 1'b1;
                    dbus_we    = we_q;
                    dbus_addr  = {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                    dbus_wdata = wdata_rep;
                    dbus_wstrb = we_q ? (size_mask << off_q) : '0;
                end
                DONE: begin
                    writeregM = writereg_q;
                    rdM       = rdata_q;
                    if (err_q) excM = 1'b1;
                    else       regwriteM = regwrite_q & ~we_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu6_memstage.sv
// Directed bench for cpu6_memstage: pass-through, loads/stores with lane steering,
// exceptions, bus errors, flush draining and reset during an access.
module tb_cpu6_memstage;

    logic        clk = 1'b0;
    logic        reset;
    logic        memreadE2M, memwriteE2M;
    logic [2:0]  funct3E2M;
    logic [63:0] aluresE2M, wdataE2M;
    logic        regwriteE2M;
    logic [4:0]  writeregE2M;
    logic        flushM;
    logic        regwriteM;
    logic [4:0]  writeregM;
    logic [63:0] rdM;
    logic        stallM, excM;
    logic        dbus_req, dbus_we;
    logic [63:0] dbus_addr, dbus_wdata;
    logic [7:0]  dbus_wstrb;
    logic        dbus_ack;
    logic [63:0] dbus_rdata;
    logic        dbus_err;

    int total = 0;
    int bad   = 0;

    int          op_stalls, op_reqs;
    logic        op_done, op_rw, op_exc, op_we;
    logic [4:0]  op_wr;
    logic [63:0] op_rd, op_addr, op_wdata, op_strb;

    cpu6_memstage #(.XLEN(64), .RFIDX_WIDTH(5)) dut (
        .clk(clk), .reset(reset),
        .memreadE2M(memreadE2M), .memwriteE2M(memwriteE2M), .funct3E2M(funct3E2M),
        .aluresE2M(aluresE2M), .wdataE2M(wdataE2M), .regwriteE2M(regwriteE2M),
        .writeregE2M(writeregE2M), .flushM(flushM),
        .regwriteM(regwriteM), .writeregM(writeregM), .rdM(rdM),
        .stallM(stallM), .excM(excM),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata), .dbus_err(dbus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        memreadE2M  = 1'b0;
        memwriteE2M = 1'b0;
        funct3E2M   = 3'b000;
        aluresE2M   = '0;
        wdataE2M    = '0;
        regwriteE2M = 1'b0;
        writeregE2M = '0;
        flushM      = 1'b0;
    endtask

    // Runs one memory instruction from its first MEM cycle up to the first unstalled cycle.
    task automatic mem_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] wreg,
                          input int ack_delay, input logic [63:0] rdata, input logic err);
        memreadE2M  = rd;
        memwriteE2M = wr;
        funct3E2M   = f3;
        aluresE2M   = addr;
        wdataE2M    = wd;
        regwriteE2M = rd;
        writeregE2M = wreg;
        op_stalls = 0; op_reqs = 0; op_done = 1'b0;
        op_rd = '0; op_rw = 1'b0; op_wr = '0; op_exc = 1'b0; op_we = 1'b0;
        op_addr = '0; op_wdata = '0; op_strb = '0;
        for (int c = 0; c < 30 && !op_done; c++) begin
            #1;
            if (dbus_req) begin
                op_reqs++;
                op_addr  = dbus_addr;
                op_wdata = dbus_wdata;
                op_strb  = {56'd0, dbus_wstrb};
                op_we    = dbus_we;
                if (op_reqs == ack_delay) begin
                    dbus_ack   = 1'b1;
                    dbus_rdata = rdata;
                    dbus_err   = err;
                end
            end
            #1;
            if (stallM) op_stalls++;
            else begin
                op_done = 1'b1;
                op_rd   = rdM;
                op_rw   = regwriteM;
                op_wr   = writeregM;
                op_exc  = excM;
            end
            tick();
            dbus_ack = 1'b0;
            dbus_err = 1'b0;
            if (op_done) idle_in();
        end
        if (!op_done) check("op_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        reset = 1'b0;
        dbus_ack = 1'b0; dbus_err = 1'b0; dbus_rdata = '0;
        idle_in();
        regwriteE2M = 1'b1; writeregE2M = 5'd3; aluresE2M = 64'h55;
        repeat (2) @(posedge clk);
        #2;
        check("rst_regwrite", {63'd0, regwriteM}, 64'd0);
        check("rst_rd", rdM, 64'd0);
        check("rst_writereg", {59'd0, writeregM}, 64'd0);
        check("rst_stall_exc_req", {61'd0, stallM, excM, dbus_req}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Pass-through, and flush killing the write
        regwriteE2M = 1'b1; writeregE2M = 5'd7; aluresE2M = 64'h1234;
        #1;
        check("pt_regwrite", {63'd0, regwriteM}, 64'd1);
        check("pt_writereg", {59'd0, writeregM}, 64'd7);
        check("pt_rd", rdM, 64'h1234);
        check("pt_stall", {63'd0, stallM}, 64'd0);
        flushM = 1'b1; #1;
        check("pt_flush_regwrite", {63'd0, regwriteM}, 64'd0);
        flushM = 1'b0;
        // Stray ack in IDLE must be ignored
        dbus_ack = 1'b1; dbus_err = 1'b1; #1;
        check("stray_ack_exc", {63'd0, excM}, 64'd0);
        tick();
        dbus_ack = 1'b0; dbus_err = 1'b0;
        #1;
        check("stray_ack_req", {63'd0, dbus_req}, 64'd0);
        idle_in();
        tick();

        // LB sign extension / LBU zero extension
        mem_op(1'b1, 1'b0, 3'b000, 64'h1003, '0, 5'd5, 1, 64'h00000000_80000000, 1'b0);
        check("lb_rd", op_rd, 64'hFFFFFFFF_FFFFFF80);
        check("lb_regwrite", {63'd0, op_rw}, 64'd1);
        check("lb_writereg", {59'd0, op_wr}, 64'd5);
        check("lb_stalls", op_stalls, 64'd2);
        check("lb_addr", op_addr, 64'h1000);
        check("lb_we", {63'd0, op_we}, 64'd0);
        mem_op(1'b1, 1'b0, 3'b100, 64'h1003, '0, 5'd6, 1, 64'h00000000_80000000, 1'b0);
        check("lbu_rd", op_rd, 64'h80);
        check("lbu_stalls", op_stalls, 64'd2);

        // LW / LWU / LH at various offsets
        mem_op(1'b1, 1'b0, 3'b010, 64'h4004, '0, 5'd9, 1, 64'h89ABCDEF_01234567, 1'b0);
        check("lw_rd", op_rd, 64'hFFFFFFFF_89ABCDEF);
        mem_op(1'b1, 1'b0, 3'b110, 64'h4004, '0, 5'd9, 1, 64'h89ABCDEF_01234567, 1'b0);
        check("lwu_rd", op_rd, 64'h00000000_89ABCDEF);
        mem_op(1'b1, 1'b0, 3'b001, 64'h4002, '0, 5'd9, 1, 64'h89ABCDEF_01234567, 1'b0);
        check("lh_rd", op_rd, 64'h0123);
        mem_op(1'b1, 1'b0, 3'b101, 64'h4006, '0, 5'd9, 1, 64'h89ABCDEF_01234567, 1'b0);
        check("lhu_rd", op_rd, 64'h89AB);

        // Stores: lane replication and strobes
        mem_op(1'b0, 1'b1, 3'b001, 64'h2006, 64'hABCD, 5'd4, 1, '0, 1'b0);
        check("sh_strb", op_strb, 64'hC0);
        check("sh_wdata", op_wdata, 64'hABCDABCD_ABCDABCD);
        check("sh_regwrite", {63'd0, op_rw}, 64'd0);
        check("sh_we", {63'd0, op_we}, 64'd1);
        check("sh_addr", op_addr, 64'h2000);
        mem_op(1'b0, 1'b1, 3'b000, 64'h5005, 64'h11223344_55667788, 5'd4, 1, '0, 1'b0);
        check("sb_strb", op_strb, 64'h20);
        check("sb_wdata", op_wdata, 64'h88888888_88888888);
        mem_op(1'b0, 1'b1, 3'b010, 64'h5004, 64'h11223344_55667788, 5'd4, 1, '0, 1'b0);
        check("sw_strb", op_strb, 64'hF0);
        check("sw_wdata", op_wdata, 64'h55667788_55667788);
        mem_op(1'b0, 1'b1, 3'b011, 64'h6000, 64'h11223344_55667788, 5'd4, 1, '0, 1'b0);
        check("sd_strb", op_strb, 64'hFF);
        check("sd_wdata", op_wdata, 64'h11223344_55667788);

        // Exceptions: misaligned LW, illegal funct3 load and store
        mem_op(1'b1, 1'b0, 3'b010, 64'h3002, '0, 5'd8, 1, '0, 1'b0);
        check("mis_exc", {63'd0, op_exc}, 64'd1);
        check("mis_reqs", op_reqs, 64'd0);
        check("mis_regwrite", {63'd0, op_rw}, 64'd0);
        check("mis_stalls", op_stalls, 64'd0);
        #1;
        check("mis_exc_pulse", {63'd0, excM}, 64'd0);
        check("mis_req_after", {63'd0, dbus_req}, 64'd0);
        tick();
        mem_op(1'b1, 1'b0, 3'b111, 64'h3000, '0, 5'd8, 1, '0, 1'b0);
        check("ill_load_exc", {62'd0, op_exc, op_rw}, 64'd2);
        mem_op(1'b0, 1'b1, 3'b100, 64'h3000, '0, 5'd8, 1, '0, 1'b0);
        check("ill_store_exc", {63'd0, op_exc}, 64'd1);
        check("ill_store_reqs", op_reqs, 64'd0);
        mem_op(1'b1, 1'b0, 3'b011, 64'h3004, '0, 5'd8, 1, '0, 1'b0);
        check("mis_ld_exc", {63'd0, op_exc}, 64'd1);

        // Bus error with a 5-cycle ack
        mem_op(1'b1, 1'b0, 3'b011, 64'h4000, '0, 5'd10, 5, 64'hDEAD, 1'b1);
        check("err_exc", {63'd0, op_exc}, 64'd1);
        check("err_regwrite", {63'd0, op_rw}, 64'd0);
        check("err_stalls", op_stalls, 64'd6);
        check("err_reqs", op_reqs, 64'd5);

        // Flush while BUSY, ack two cycles later
        memreadE2M = 1'b1; funct3E2M = 3'b011; aluresE2M = 64'h7000;
        regwriteE2M = 1'b1; writeregE2M = 5'd11;
        #1;
        check("fl_issue_stall", {63'd0, stallM}, 64'd1);
        tick();
        flushM = 1'b1; #1;
        check("fl_busy_req", {63'd0, dbus_req}, 64'd1);
        tick();
        idle_in(); #1;
        check("fl_drain_req_stall", {62'd0, dbus_req, stallM}, 64'd3);
        check("fl_drain_regwrite", {63'd0, regwriteM}, 64'd0);
        tick();
        dbus_ack = 1'b1; dbus_rdata = 64'h1111; #1;
        check("fl_ack_stall", {62'd0, stallM, regwriteM}, 64'd2);
        tick();
        dbus_ack = 1'b0; #1;
        check("fl_after_stall", {62'd0, stallM, dbus_req}, 64'd0);
        check("fl_after_regwrite", {62'd0, regwriteM, excM}, 64'd0);
        tick();

        // Reset asserted during BUSY
        memreadE2M = 1'b1; funct3E2M = 3'b011; aluresE2M = 64'h8000;
        regwriteE2M = 1'b1; writeregE2M = 5'd12;
        tick();
        #1;
        check("rb_req_before", {63'd0, dbus_req}, 64'd1);
        reset = 1'b0; #1;
        check("rb_req", {63'd0, dbus_req}, 64'd0);
        check("rb_addr", dbus_addr, 64'd0);
        check("rb_rd", rdM, 64'd0);
        check("rb_ctrl", {59'd0, regwriteM, stallM, excM, dbus_we, |dbus_wstrb}, 64'd0);
        tick();
        idle_in();
        reset = 1'b1;
        regwriteE2M = 1'b1; writeregE2M = 5'd2; aluresE2M = 64'hBEEF;
        #1;
        check("rb_recover_rd", rdM, 64'hBEEF);
        check("rb_recover_ctrl", {61'd0, regwriteM, stallM, dbus_req}, 64'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
